stringgen_tx: RTL and testbench
===============================

// Module: stringgen_tx
// PURPOSE
//  Serial bit-string transmitter: the sending end of the bit stream the string
//  recognizer consumes. Latches a pattern from the switch bank and sends it
//  one bit at a time, MSB-first, over a valid/ready handshake. Supports one-shot
//  or repeat mode, abort, and a cumulative sent-bit counter for the 7-seg path.
// PARAMETERS
//  WIDTH  16  pattern width in bits (max string length)
//  LEN_W  5   width of len port; must satisfy 2**LEN_W > WIDTH
// PORTS
//  clk         in   1        system clock (slow generated clock in the FPGA top)
//  clr_n       in   1        asynchronous active-low reset
//  start       in   1        1-cycle pulse: latch pattern/len, begin sending
//  halt        in   1        1-cycle pulse: abort transmission, return to IDLE
//  repeat      in   1        1: restart the same string after its last bit
//  pattern     in   WIDTH    bits to send; pattern[len-1] is sent first
//  len         in   LEN_W    string length 1..WIDTH; 0 or >WIDTH means WIDTH
//  bit_out     out  1        current serial bit
//  bit_valid   out  1        bit_out is valid
//  bit_ready   in   1        receiver accepts bit_out this cycle
//  busy        out  1        high in SEND
//  done        out  1        1-cycle pulse after the last bit of a one-shot string
//  sent_count  out  16       total bits accepted since reset
// BEHAVIOUR
//  Reset (clr_n=0, async): state=IDLE; bit_out=0, bit_valid=0, busy=0, done=0,
//   sent_count=0, shift reg/shadow/bit index=0. Outputs are registered.
//  States: IDLE, SEND, DONE.
//  IDLE: on start: shadow<=pattern<<(WIDTH-len_eff); shreg<=same; idx<=len_eff;
//   state<=SEND. bit_valid rises on the edge after start (latency 1 cycle).
//  SEND: bit_valid=1, busy=1, bit_out=shreg[WIDTH-1].
//   - Transfer occurs on any edge with bit_valid&bit_ready: shreg<<=1, idx-=1,
//     sent_count+=1 (saturates at 16'hFFFF, no wrap).
//   - Without bit_ready, bit_out and bit_valid hold stable (no change).
//   - Last bit transferred (idx==1): repeat=1 -> shreg<=shadow, idx<=len_eff,
//     stay SEND, no valid gap; repeat=0 -> DONE, bit_valid=0 next cycle.
//   - repeat is sampled only at the last-bit transfer.
//  DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored.
//  halt: from SEND or DONE -> IDLE next edge; bit_valid=0, done not pulsed;
//   a transfer on the same edge as halt still counts in sent_count.
//  Priority: halt > start. start while in SEND is ignored (pattern not relatched).
//  pattern/len changes after start have no effect until the next start.
//  len_eff = (len==0 || len>WIDTH) ? WIDTH : len.
//  Reset mid-SEND: immediate return to reset values; nothing further transmitted.
// TESTING
//  1. pattern=16'h000B,len=4,ready=1,start -> bits 1,0,1,1 on 4 consecutive
//     cycles from the edge after start; done pulse once; sent_count=4.
//  2. Same as 1 with ready low 3 cycles mid-bit -> bit_out/bit_valid held;
//     sequence unchanged; sent_count=4 at end.
//  3. len=0, pattern=16'h8001 -> 16 bits: 1, fourteen 0s, 1; sent_count=16.
//  4. repeat=1, len=3, pattern=3'b110, ready=1 for 9 cycles -> 110110110,
//     no gap, no done; sent_count=9; then halt -> bit_valid=0 next cycle, no done.
//  5. start during SEND with different pattern -> ignored; original finishes.
//  6. clr_n low mid-string -> all outputs 0 immediately (async); sent_count
//     saturation: preload via long repeat run -> holds 16'hFFFF.

Source files
------------

// File: rtl/stringgen_tx.sv
// Serial bit-string transmitter: latches a switch-bank pattern and shifts it out
// MSB-first over a valid/ready handshake, with repeat, abort and a sent-bit counter.
module stringgen_tx #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             halt,
  input  logic             repeat_mode,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sent_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_lat_q, len_lat_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               bit_out_q, bit_out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [LEN_W-1:0]   len_eff;
  logic [WIDTH-1:0]   loaded;
  logic               xfer;

  always_comb begin
    len_eff = ((len == '0) || (len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : len;
    // Left-justify so the first bit to send always sits at the MSB.
    loaded  = pattern << (LEN_W'(WIDTH) - len_eff);
    xfer    = (state_q == S_SEND) && valid_q && bit_ready;
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    len_lat_d = len_lat_q;
    cnt_d     = cnt_q;
    bit_out_d = bit_out_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // A transfer on the abort edge still counts.
    if (xfer && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !halt) begin
          shadow_d  = loaded;
          shreg_d   = loaded;
          idx_d     = len_eff;
          len_lat_d = len_eff;
          bit_out_d = loaded[WIDTH-1];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (halt) begin
          state_d   = S_IDLE;
          valid_d   = 1'b0;
          busy_d    = 1'b0;
          bit_out_d = 1'b0;
        end else if (xfer) begin
          if (idx_q == LEN_W'(1)) begin
            if (repeat_mode) begin
              shreg_d   = shadow_q;
              idx_d     = len_lat_q;
              bit_out_d = shadow_q[WIDTH-1];
            end else begin
              state_d   = S_DONE;
              valid_d   = 1'b0;
              busy_d    = 1'b0;
              bit_out_d = 1'b0;
              done_d    = 1'b1;
            end
          end else begin
            shreg_d   = shreg_q << 1;
            idx_d     = idx_q - LEN_W'(1);
            bit_out_d = shreg_q[WIDTH-2];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        bit_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      shadow_q  <= '0;
      idx_q     <= '0;
      len_lat_q <= '0;
      cnt_q     <= '0;
      bit_out_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      len_lat_q <= len_lat_d;
      cnt_q     <= cnt_d;
      bit_out_q <= bit_out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_count = cnt_q;

endmodule

// File: tb/tb_stringgen_tx.sv
// Scoreboard bench for stringgen_tx: driver queues expected bits per string,
// a negedge monitor pops them on every accepted transfer.
module tb_stringgen_tx;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned LEN_W = 5;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             start, halt, repeat_mode;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             bit_out, bit_valid, bit_ready;
  logic             busy, done;
  logic [15:0]      sent_count;

  stringgen_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .halt(halt),
    .repeat_mode(repeat_mode), .pattern(pattern), .len(len),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .busy(busy), .done(done), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit b;
    bit last;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          done_seen = 0;
  int          exp_done_total = 0;
  logic [15:0] model_cnt = '0;
  bit          exp_done_next = 0;
  bit          prev_valid = 0, prev_ready = 0, prev_halt = 0, prev_bit = 0;
  bit          rnd_ready = 0;
  int          hold_low = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready generator: random backpressure or held low for a requested stretch.
  always @(posedge clk) begin
    #1;
    if (hold_low > 0) begin
      bit_ready = 1'b0;
      hold_low--;
    end else if (rnd_ready) begin
      bit_ready = ($urandom_range(0, 3) != 0);
    end else begin
      bit_ready = 1'b1;
    end
  end

  // Monitor: all checks happen mid-cycle; a valid&ready seen here is the
  // transfer that the following rising edge performs.
  always @(negedge clk) begin
    exp_t e;
    if (!clr_n) begin
      prev_valid    = 0;
      exp_done_next = 0;
    end else begin
      chk("busy_eq_valid", {31'd0, busy}, {31'd0, bit_valid});
      chk("sent_count", {16'd0, sent_count}, {16'd0, model_cnt});
      if (exp_done_next) begin
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("valid_after_last", {31'd0, bit_valid}, 32'd0);
      end else begin
        chk("done_quiet", {31'd0, done}, 32'd0);
      end
      if (done) done_seen++;
      if (prev_valid && !prev_ready && !prev_halt) begin
        chk("hold_valid", {31'd0, bit_valid}, 32'd1);
        chk("hold_bit", {31'd0, bit_out}, {31'd0, prev_bit});
      end
      exp_done_next = 0;
      if (bit_valid && q.size() == 0) begin
        chk("unexpected_valid", {31'd0, bit_valid}, 32'd0);
      end else if (bit_valid && bit_ready) begin
        e = q.pop_front();
        chk("bit", {31'd0, bit_out}, {31'd0, e.b});
        exp_done_next = e.last;
        if (model_cnt != 16'hFFFF) model_cnt++;
      end
      prev_valid = bit_valid;
      prev_ready = bit_ready;
      prev_halt  = halt;
      prev_bit   = bit_out;
    end
  end

  // Reference: string is pattern[len_eff-1:0], most significant first.
  task automatic do_start(input logic [WIDTH-1:0] pat, input int l, input bit rep,
                          input int copies, input bit final_last);
    int le;
    le = (l == 0 || l > int'(WIDTH)) ? int'(WIDTH) : l;
    for (int c = 0; c < copies; c++) begin
      for (int i = le - 1; i >= 0; i--) begin
        exp_t e;
        e.b    = pat[i];
        e.last = final_last && (c == copies - 1) && (i == 0);
        q.push_back(e);
      end
    end
    if (final_last) exp_done_total++;
    pattern     = pat;
    len         = LEN_W'(l);
    repeat_mode = rep;
    start       = 1'b1;
    tick();
    start   = 1'b0;
    pattern = WIDTH'($urandom);
    len     = LEN_W'($urandom);
    @(negedge clk);
    chk("start_latency", {31'd0, bit_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_size(input int n, input int budget);
    int k = 0;
    while (q.size() > n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_timeout", {31'd0, (q.size() > n)}, 32'd0);
  endtask

  task automatic finish_string();
    wait_size(0, 400);
    q.delete();
    repeat (3) tick();
    chk("done_count", done_seen, exp_done_total);
  endtask

  task automatic do_halt();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    q.delete();
    repeat (3) tick();
    chk("done_count_halt", done_seen, exp_done_total);
  endtask

  initial begin
    clr_n = 1'b0; start = 0; halt = 0; repeat_mode = 0;
    pattern = '0; len = '0; bit_ready = 1'b1;
    repeat (3) tick();
    chk("rst_bit_out", {31'd0, bit_out}, 32'd0);
    chk("rst_valid", {31'd0, bit_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {16'd0, sent_count}, 32'd0);
    clr_n = 1'b1;
    repeat (2) tick();

    // Directed: 1011, then with a 3-cycle stall, then 16-bit default length.
    do_start(16'h000B, 4, 0, 1, 1);
    finish_string();
    chk("count_after_t1", {16'd0, sent_count}, 32'd4);
    do_start(16'h000B, 4, 0, 1, 1);
    hold_low = 3;
    finish_string();
    chk("count_after_t2", {16'd0, sent_count}, 32'd8);
    do_start(16'h8001, 0, 0, 1, 1);
    finish_string();
    chk("count_after_t3", {16'd0, sent_count}, 32'd24);

    // Repeat 110 for nine bits, then abort.
    do_start(16'h0006, 3, 1, 4, 0);
    wait_size(3, 100);
    chk("count_after_9", {16'd0, sent_count}, 32'd33);
    do_halt();

    // Repeat sampled only at the last bit: drop it during the second copy.
    do_start(16'h0005, 3, 1, 2, 1);
    wait_size(3, 100);
    repeat_mode = 1'b0;
    finish_string();

    // halt beats start in IDLE: nothing must be sent.
    start = 1'b1; halt = 1'b1;
    tick();
    start = 1'b0; halt = 1'b0;
    repeat (4) tick();

    // Randomized strings with backpressure and spurious starts mid-send.
    rnd_ready = 1;
    for (int n = 0; n < 30; n++) begin
      do_start(WIDTH'($urandom), $urandom_range(0, 31), 0, 1, 1);
      if ($urandom_range(0, 2) == 0) begin
        pattern = WIDTH'($urandom);
        len     = LEN_W'($urandom_range(1, 16));
        start   = 1'b1;
        tick();
        start   = 1'b0;
      end
      finish_string();
    end
    for (int n = 0; n < 4; n++) begin
      do_start(WIDTH'($urandom), $urandom_range(1, 16), 1, 5, 0);
      wait_size($urandom_range(2, 20), 600);
      do_halt();
    end
    rnd_ready = 0;

    // Async reset in the middle of a string.
    do_start(16'hA5A5, 16, 0, 1, 1);
    repeat (3) tick();
    #1;
    clr_n = 1'b0;
    #1;
    chk("arst_bit_out", {31'd0, bit_out}, 32'd0);
    chk("arst_valid", {31'd0, bit_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_count", {16'd0, sent_count}, 32'd0);
    q.delete();
    model_cnt      = '0;
    exp_done_total = 0;
    done_seen      = 0;
    repeat (2) tick();
    #1;
    clr_n = 1'b1;
    repeat (4) tick();

    // Saturation: long repeat run past 65535 transfers.
    do_start(16'hC3A1, 16, 1, 4100, 0);
    wait_size(16, 70000);
    chk("count_saturated", {16'd0, sent_count}, 32'h0000FFFF);
    do_halt();
    chk("count_sat_hold", {16'd0, sent_count}, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
